// File: rtl/stopwatch_pkg.sv
// Shared BCD types, digit limits and the load-saturation helper for the stopwatch core.

package stopwatch_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t DIGIT_MAX_9 = 4'd9;
   localparam bcd_t DIGIT_MAX_5 = 4'd5;
   localparam bcd_t BCD_ZERO    = 4'd0;

   // Clamp a preload digit to the largest legal value for its position.
   function automatic bcd_t sat_bcd(input bcd_t val, input bcd_t max);
      return (val > max) ? max : val;
   endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit (0..MAX) with clear/load/step; cy_o flags carry (up) or borrow (down).

module bcd_digit_counter
   import stopwatch_pkg::*;
#(
   parameter bcd_t MAX = DIGIT_MAX_9
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic down_i,
   input  logic clr_i,
   input  logic ld_i,
   input  bcd_t ld_val_i,
   output bcd_t q_o,
   output logic cy_o
);

   bcd_t q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (clr_i) begin
         q_d = BCD_ZERO;
      end else if (ld_i) begin
         q_d = ld_val_i;
      end else if (en_i) begin
         if (down_i) begin
            q_d = (q_q == BCD_ZERO) ? MAX : q_q - 4'd1;
         end else begin
            q_d = (q_q == MAX) ? BCD_ZERO : q_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q <= BCD_ZERO;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o  = q_q;
   assign cy_o = en_i && (down_i ? (q_q == BCD_ZERO) : (q_q == MAX));

endmodule

// File: rtl/stopwatch_core.sv
// BCD m:ss.dc up/down stopwatch with prescaler, preload, DONE/WRAP pulses.
// Optional lap/split display freeze when STOPWATCH_SPLIT_LAP_EN is defined.

module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 500000,
   parameter int unsigned MIN_DIGITS = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    enable_i,
   input  logic                    clear_i,
   input  logic                    load_i,
   input  logic                    mode_down_i,
   input  logic [4*MIN_DIGITS-1:0] ld_min_i,
   input  logic [3:0]              ld_tensec_i,
   input  logic [3:0]              ld_sec_i,
   input  logic                    lap_i,
   output logic [4*MIN_DIGITS-1:0] min_o,
   output logic [3:0]              tensec_o,
   output logic [3:0]              sec_o,
   output logic [3:0]              decisec_o,
   output logic [3:0]              centisec_o,
   output logic                    done_o,
   output logic                    wrap_o,
   output logic                    lap_active_o
);

   localparam int unsigned NumDig = 4 + MIN_DIGITS;
   localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_DIV - 1);

   logic [PrescW-1:0] presc_q, presc_d;
   logic halt_q, halt_d, done_q, done_d, wrap_q, wrap_d;
   logic run, tick, step, all_zero, at_one, cnt_en;
   logic [NumDig:0]        cy;
   logic [NumDig-1:0][3:0] dig, ld_val, disp;

   // Digit index 0 = centiseconds, 3 = tens of seconds, 4.. = minutes (low first).
   always_comb begin
      ld_val    = '0;
      ld_val[2] = sat_bcd(ld_sec_i, DIGIT_MAX_9);
      ld_val[3] = sat_bcd(ld_tensec_i, DIGIT_MAX_5);
      for (int i = 0; i < int'(MIN_DIGITS); i++) begin
         ld_val[4+i] = sat_bcd(ld_min_i[4*i+:4], DIGIT_MAX_9);
      end
   end

   for (genvar g = 0; g < NumDig; g++) begin : g_dig
      localparam bcd_t Max = (g == 3) ? DIGIT_MAX_5 : DIGIT_MAX_9;
      bcd_digit_counter #(.MAX(Max)) u_dig (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .en_i    (cy[g]),
         .down_i  (mode_down_i),
         .clr_i   (clear_i),
         .ld_i    (load_i),
         .ld_val_i(ld_val[g]),
         .q_o     (dig[g]),
         .cy_o    (cy[g+1])
      );
   end

   assign run      = enable_i && !halt_q;
   assign tick     = run && (presc_q == PrescLast);
   assign step     = tick && !clear_i && !load_i;
   assign all_zero = (dig == '0);
   assign at_one   = (dig[NumDig-1:1] == '0) && (dig[0] == 4'd1);
   // A down tick at 0:00.00 must not underflow, so the cascade is gated there.
   assign cnt_en   = step && !(mode_down_i && all_zero);
   assign cy[0]    = cnt_en;

   always_comb begin
      done_d  = step && mode_down_i && (all_zero || at_one);
      wrap_d  = step && !mode_down_i && cy[NumDig];
      halt_d  = halt_q;
      presc_d = presc_q;
      if (clear_i || load_i) begin
         halt_d  = 1'b0;
         presc_d = '0;
      end else begin
         if (done_d) halt_d = 1'b1;
         if (run) presc_d = tick ? '0 : presc_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc_q <= '0;
         halt_q  <= 1'b0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         halt_q  <= halt_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
      end
   end

`ifdef STOPWATCH_SPLIT_LAP_EN
   logic                   lap_active_q, lap_active_d;
   logic [NumDig-1:0][3:0] lap_q, lap_d;

   always_comb begin
      lap_active_d = lap_active_q;
      lap_d        = lap_q;
      if (clear_i || load_i) begin
         lap_active_d = 1'b0;
      end else if (lap_i) begin
         lap_active_d = !lap_active_q;
         if (!lap_active_q) lap_d = dig;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lap_active_q <= 1'b0;
         lap_q        <= '0;
      end else begin
         lap_active_q <= lap_active_d;
         lap_q        <= lap_d;
      end
   end

   assign disp         = lap_active_q ? lap_q : dig;
   assign lap_active_o = lap_active_q;
`else
   logic unused_lap;
   assign unused_lap   = lap_i;
   assign disp         = dig;
   assign lap_active_o = 1'b0;
`endif

   assign centisec_o = disp[0];
   assign decisec_o  = disp[1];
   assign sec_o      = disp[2];
   assign tensec_o   = disp[3];
   assign min_o      = disp[NumDig-1:4];
   assign done_o     = done_q;
   assign wrap_o     = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Randomised + directed bench; reference model tracks time as total centiseconds.

module tb_stopwatch_core;

   localparam int unsigned TD = 2;
   localparam int unsigned MD = 1;
   localparam int MaxT = 6000 * (10 ** MD);
`ifdef STOPWATCH_SPLIT_LAP_EN
   localparam bit LapEn = 1'b1;
`else
   localparam bit LapEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0, clr = 1'b0, ld = 1'b0, dn = 1'b0, lap = 1'b0;
   logic [4*MD-1:0] ld_min = '0;
   logic [3:0] ld_ts = '0, ld_s = '0;
   logic [4*MD-1:0] min_o;
   logic [3:0] ts_o, s_o, d_o, c_o;
   logic done_o, wrap_o, lap_act_o;

   always #5 clk = ~clk;

   stopwatch_core #(.TICK_DIV(TD), .MIN_DIGITS(MD)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .enable_i    (en),
      .clear_i     (clr),
      .load_i      (ld),
      .mode_down_i (dn),
      .ld_min_i    (ld_min),
      .ld_tensec_i (ld_ts),
      .ld_sec_i    (ld_s),
      .lap_i       (lap),
      .min_o       (min_o),
      .tensec_o    (ts_o),
      .sec_o       (s_o),
      .decisec_o   (d_o),
      .centisec_o  (c_o),
      .done_o      (done_o),
      .wrap_o      (wrap_o),
      .lap_active_o(lap_act_o)
   );

   int checks = 0;
   int failures = 0;
   int tot, presc, lap_val, done_cnt, wrap_cnt;
   bit halt, done_e, wrap_e, lap_act;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   function automatic logic [31:0] disp_of(input int v);
      int m, mb;
      m  = v / 6000;
      mb = 0;
      for (int i = 0; i < int'(MD); i++) mb |= ((m / (10 ** i)) % 10) << (4 * i);
      return 32'((mb << 16) | (((v / 1000) % 6) << 12) | (((v / 100) % 10) << 8) |
                 (((v / 10) % 10) << 4) | (v % 10));
   endfunction

   task automatic model_reset();
      tot = 0; presc = 0; lap_val = 0;
      halt = 0; done_e = 0; wrap_e = 0; lap_act = 0;
   endtask

   task automatic model_update();
      bit tk;
      int lm;
      tk = en && !halt && (presc == int'(TD) - 1);
      done_e = 0;
      wrap_e = 0;
      if (clr) begin
         tot = 0; presc = 0; halt = 0; lap_act = 0;
      end else if (ld) begin
         lm = 0;
         for (int i = 0; i < int'(MD); i++) lm += sat(int'(ld_min[4*i+:4]), 9) * (10 ** i);
         tot = lm * 6000 + sat(int'(ld_ts), 5) * 1000 + sat(int'(ld_s), 9) * 100;
         presc = 0; halt = 0; lap_act = 0;
      end else begin
         if (LapEn && lap) begin
            if (!lap_act) begin
               lap_val = tot;
               lap_act = 1;
            end else begin
               lap_act = 0;
            end
         end
         if (en && !halt) presc = tk ? 0 : presc + 1;
         if (tk) begin
            if (dn) begin
               if (tot <= 1) begin
                  tot = 0; done_e = 1; halt = 1;
               end else begin
                  tot--;
               end
            end else if (tot == MaxT - 1) begin
               tot = 0;
               wrap_e = 1;
            end else begin
               tot++;
            end
         end
      end
   endtask

   task automatic compare_all();
      check_eq("digits", 32'({min_o, ts_o, s_o, d_o, c_o}), disp_of(lap_act ? lap_val : tot));
      check_eq("done", 32'(done_o), 32'(done_e));
      check_eq("wrap", 32'(wrap_o), 32'(wrap_e));
      check_eq("lap_active", 32'(lap_act_o), 32'(lap_act));
      if (done_o) done_cnt++;
      if (wrap_o) wrap_cnt++;
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_load(input int m, input int t, input int s);
      ld_min = (4*MD)'(m); ld_ts = 4'(t); ld_s = 4'(s);
      ld = 1'b1;
      step();
      ld = 1'b0;
   endtask

   task automatic pulse_lap();
      lap = 1'b1;
      step();
      lap = 1'b0;
   endtask

   // Run until the model reaches target, bounded so a stuck DUT cannot hang the bench.
   task automatic run_until(input int target, input string tag);
      int n;
      n = 0;
      while (tot != target && n < 2000) begin
         step();
         n++;
      end
      check_eq(tag, 32'(tot == target), 32'd1);
   endtask

   initial begin
      model_reset();
      done_cnt = 0;
      wrap_cnt = 0;
      repeat (2) @(negedge clk);
      compare_all();
      rst_n = 1'b1;
      run(3);

      // Up across a minute boundary, then across the top (wrap).
      en = 1'b1; dn = 1'b0;
      do_load(0, 5, 9);
      run(205);
      check_eq("min_rollover", 32'({min_o, ts_o, s_o, d_o, c_o}), 32'h10002);
      do_load(9, 5, 9);
      wrap_cnt = 0;
      run(210);
      check_eq("wrap_once", 32'(wrap_cnt), 32'd1);

      // Countdown from 0:01 to zero, then halted.
      dn = 1'b1;
      do_load(0, 0, 1);
      done_cnt = 0;
      run(260);
      check_eq("done_once", 32'(done_cnt), 32'd1);
      check_eq("halt_zero", 32'({min_o, ts_o, s_o, d_o, c_o}), 32'h0);

      // Down tick with count already zero.
      do_load(0, 0, 0);
      done_cnt = 0;
      run(6);
      check_eq("done_from_zero", 32'(done_cnt), 32'd1);

      // Freeze with ENABLE low, then CLEAR beats LOAD, then saturation.
      dn = 1'b0;
      do_load(1, 2, 3);
      run(37);
      en = 1'b0;
      run(10);
      en = 1'b1;
      run(9);
      clr = 1'b1; ld = 1'b1; ld_min = 4'd7; ld_ts = 4'd3; ld_s = 4'd3;
      step();
      clr = 1'b0; ld = 1'b0;
      check_eq("clear_wins", 32'({min_o, ts_o, s_o, d_o, c_o}), 32'h0);
      do_load(0, 7, 12);
      check_eq("sat_tensec", 32'(ts_o), 32'd5);
      check_eq("sat_sec", 32'(s_o), 32'd9);

      // Lap freeze and release.
      do_load(0, 0, 3);
      run_until(321, "reach_321");
      pulse_lap();
      run(30);
      run_until(500, "reach_500");
      pulse_lap();
      run(6);

      // Asynchronous reset mid-count at 0:12.34.
      do_load(0, 1, 2);
      run_until(1234, "reach_1234");
      rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("async_digits", 32'({min_o, ts_o, s_o, d_o, c_o}), 32'h0);
      check_eq("async_done", 32'(done_o), 32'd0);
      check_eq("async_wrap", 32'(wrap_o), 32'd0);
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         en     = ($urandom % 10) != 0;
         clr    = ($urandom % 150) == 0;
         ld     = ($urandom % 60) == 0;
         lap    = ($urandom % 25) == 0;
         if (($urandom % 80) == 0) dn = !dn;
         ld_min = (4*MD)'($urandom);
         ld_ts  = 4'($urandom);
         ld_s   = 4'($urandom % 3);
         step();
      end
      clr = 1'b0; ld = 1'b0; lap = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
